// File: rtl/serial_subtractor_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor controller.
// The master issues operands with start; the slave returns the result with done.
interface serial_subtractor_ctrl_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial N-bit subtractor: one full-subtractor cell walks the operands
// LSB-first, one bit per clock, with the borrow carried in a flip-flop.
module serial_subtractor_ctrl #(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_subtractor_ctrl_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  x_sr;
  logic [N-1:0]  y_sr;
  logic [N-1:0]  r_sr;
  logic          borrow;
  logic [CW-1:0] cnt;

  logic          cell_d;
  logic          cell_bo;
  logic [N-1:0]  r_next;

  // Full-subtractor cell on the current LSBs and the held borrow.
  assign cell_d  = x_sr[0] ^ y_sr[0] ^ borrow;
  assign cell_bo = (~x_sr[0] & y_sr[0]) | (~x_sr[0] & borrow) | (y_sr[0] & borrow);

  // NOTE: every signal driven in always_comb gets a full default first so no latch is inferred.
  always_comb begin
    r_next        = r_sr >> 1;
    r_next[N-1]   = cell_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      x_sr     <= '0;
      y_sr     <= '0;
      r_sr     <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            x_sr     <= bus.a;
            y_sr     <= bus.b;
            borrow   <= bus.bin;
            cnt      <= '0;
            state    <= RUN;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          r_sr   <= r_next;
          x_sr   <= x_sr >> 1;
          y_sr   <= y_sr >> 1;
          borrow <= cell_bo;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            bus.diff <= r_next;
            bus.bout <= cell_bo;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl: stimulus pushes expected results
// and completion cycles; a negedge monitor pops and compares on every done.
module tb_serial_subtractor_ctrl;

  localparam int N = 8;

  typedef struct {
    logic [N-1:0] diff;
    logic         bout;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  serial_subtractor_ctrl_if #(.N(N)) ifc ();

  serial_subtractor_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && ifc.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", 32'(ifc.diff), 32'(e.diff));
        check("bout", 32'(ifc.bout), 32'(e.bout));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        check("busy_in_done", 32'(ifc.busy), 32'd0);
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.done === 1'b1) return;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  // Drive one start pulse in IDLE; returns at the negedge after acceptance.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                       input logic [N-1:0] ed, input logic eb, input bit expect_done);
    exp_t e;
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.a     = a;
    ifc.b     = b;
    ifc.bin   = bin;
    @(negedge clk);
    ifc.start = 1'b0;
    check("busy_after_accept", 32'(ifc.busy), 32'd1);
    if (expect_done) begin
      e.diff = ed;
      e.bout = eb;
      e.cyc  = cyc + N;
      sb.push_back(e);
    end
  endtask

  initial begin
    exp_t e;
    int   acc;
    ifc.start = 1'b0;
    ifc.a     = '0;
    ifc.b     = '0;
    ifc.bin   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_diff", 32'(ifc.diff), 32'd0);
    check("rst_bout", 32'(ifc.bout), 32'd0);
    rst = 1'b0;

    // Directed vectors.
    issue(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b1); wait_done();
    issue(8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b1); wait_done();
    issue(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b1); wait_done();
    issue(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1); wait_done();

    // Start pulses during RUN and DONE must be ignored.
    issue(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    ifc.start = 1'b1; ifc.a = 8'h01; ifc.b = 8'h01;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done();
    ifc.start = 1'b1; ifc.a = 8'h01; ifc.b = 8'h01;
    @(negedge clk);
    ifc.start = 1'b0;
    check("idle_after_done_busy", 32'(ifc.busy), 32'd0);
    repeat (14) @(negedge clk);
    check("diff_held", 32'(ifc.diff), 32'h23);

    // Asynchronous reset in the middle of RUN discards the operation.
    issue(8'hAA, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(ifc.busy), 32'd0);
    check("midrst_done", 32'(ifc.done), 32'd0);
    check("midrst_diff", 32'(ifc.diff), 32'd0);
    check("midrst_bout", 32'(ifc.bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1); wait_done();

    // Back-to-back with start held high: completions every N+2 cycles.
    @(negedge clk);
    ifc.start = 1'b1; ifc.a = 8'h80; ifc.b = 8'h01; ifc.bin = 1'b0;
    @(negedge clk);
    acc = cyc;
    e.diff = 8'h7F; e.bout = 1'b0; e.cyc = acc + N;             sb.push_back(e);
    e.diff = 8'hEF; e.bout = 1'b1; e.cyc = acc + N + (N + 2);   sb.push_back(e);
    e.diff = 8'hFF; e.bout = 1'b1; e.cyc = acc + N + 2*(N + 2); sb.push_back(e);
    wait_done();
    ifc.a = 8'h10; ifc.b = 8'h20; ifc.bin = 1'b1;
    wait_done();
    ifc.a = 8'h7F; ifc.b = 8'h7F; ifc.bin = 1'b1;
    wait_done();
    ifc.start = 1'b0;
    repeat (14) @(negedge clk);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
